// File: rtl/mem_bus_pkg.sv
// Shared memory-bus encoding and address map.
// Imported by both ends of the bus.
package mem_bus_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;

  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } resp_state_t;

endpackage

// File: rtl/mem_bus_responder_sync_ram.sv
// Single-port write-first RAM, registered read output.
// INIT_FILE kept for interface compatibility.
module sync_ram #(
  parameter int    WIDTH     = 16,
  parameter int    DEPTH     = 256,
  parameter string INIT_FILE = "",
  localparam int   AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
        rdata_q     <= wdata;
      end else begin
        rdata_q     <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: RAM, LED register, switch port.
// Define MEM_BUS_PERF_CNT_EN to add rd_count/wr_count outputs.
module mem_bus_responder #(
  parameter int              DATA_W    = mem_bus_pkg::DATA_W,
  parameter int              ADDR_W    = mem_bus_pkg::ADDR_W,
  parameter int              RAM_WORDS = 256,
  parameter string           INIT_FILE = "data.txt",
  parameter logic [ADDR_W-1:0] LED_ADDR = mem_bus_pkg::LED_ADDR,
  parameter logic [ADDR_W-1:0] SW_ADDR  = mem_bus_pkg::SW_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [7:0]        switches,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic [7:0]        leds,
`ifdef MEM_BUS_PERF_CNT_EN
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
`endif
  output logic              bus_err
);
  import mem_bus_pkg::*;

  localparam int RAM_AW = $clog2(RAM_WORDS);

  logic rd, wr, ill;
  logic ram_hit, sw_hit, led_hit;

  assign rd  = !reset && (mem_cmd == MREAD);
  assign wr  = !reset && (mem_cmd == MWRITE);
  assign ill = !reset && (mem_cmd == 2'b11);

  assign ram_hit = !mem_addr[ADDR_W-1];
  assign sw_hit  = (mem_addr == SW_ADDR);
  assign led_hit = (mem_addr == LED_ADDR);

  logic              ram_en, ram_we;
  logic [DATA_W-1:0] ram_rdata;

  assign ram_en = (rd || wr) && ram_hit;
  assign ram_we = wr && ram_hit;

  sync_ram #(
    .WIDTH    (DATA_W),
    .DEPTH    (RAM_WORDS),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (mem_addr[RAM_AW-1:0]),
    .wdata(write_data),
    .rdata(ram_rdata)
  );

  resp_state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = rd ? RESP : IDLE;
      RESP:    state_d = rd ? RESP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_valid = (state_q == RESP);
  end

  // src_q selects the live RAM output; once the RAM port is reused,
  // its last result is parked in dat_q so read_data keeps holding.
  logic              src_q, src_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [7:0]        leds_q, leds_d;
  logic              err_q, err_d;

  always_comb begin
    src_d  = src_q;
    dat_d  = dat_q;
    leds_d = leds_q;
    err_d  = err_q;
    if (rd) begin
      src_d = ram_hit;
      unique case (1'b1)
        ram_hit: dat_d = dat_q;
        sw_hit:  dat_d = {{(DATA_W-8){1'b0}}, switches};
        default: begin
          dat_d = '0;
          err_d = 1'b1;
        end
      endcase
    end else if (src_q) begin
      src_d = 1'b0;
      dat_d = ram_rdata;
    end
    if (wr) begin
      unique case (1'b1)
        ram_hit: leds_d = leds_q;
        led_hit: leds_d = write_data[7:0];
        default: err_d  = 1'b1;
      endcase
    end
    if (ill) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= 1'b0;
      dat_q  <= '0;
      leds_q <= '0;
      err_q  <= 1'b0;
    end else begin
      src_q  <= src_d;
      dat_q  <= dat_d;
      leds_q <= leds_d;
      err_q  <= err_d;
    end
  end

  assign read_data = src_q ? ram_rdata : dat_q;
  assign leds      = leds_q;
  assign bus_err   = err_q;

`ifdef MEM_BUS_PERF_CNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (wr) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized bench for mem_bus_responder against a
// transaction-level model of the bus map.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [7:0]  switches;
  logic [15:0] read_data;
  logic        read_valid;
  logic [7:0]  leds;
  logic        bus_err;
`ifdef MEM_BUS_PERF_CNT_EN
  logic [15:0] rd_count, wr_count;
`endif

  always #5 clk = ~clk;

  mem_bus_responder #(
    .INIT_FILE("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .write_data(write_data),
    .switches  (switches),
    .read_data (read_data),
    .read_valid(read_valid),
    .leds      (leds),
`ifdef MEM_BUS_PERF_CNT_EN
    .rd_count  (rd_count),
    .wr_count  (wr_count),
`endif
    .bus_err   (bus_err)
  );

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_RD   = 2'b01;
  localparam logic [1:0] C_WR   = 2'b10;
  localparam logic [1:0] C_BAD  = 2'b11;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_ram [256];
  logic [15:0] m_rd   = '0;
  logic        m_v    = 1'b0;
  logic [7:0]  m_leds = '0;
  logic        m_err  = 1'b0;
  logic [15:0] m_rc   = '0;
  logic [15:0] m_wc   = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One bus cycle: apply inputs, clock, advance model, compare.
  task automatic step(input logic rst, input logic [1:0] c,
                      input logic [8:0] a, input logic [15:0] d,
                      input logic [7:0] sw);
    reset      = rst;
    mem_cmd    = c;
    mem_addr   = a;
    write_data = d;
    switches   = sw;
    @(posedge clk);
    #1;
    if (rst) begin
      m_rd = '0; m_v = 1'b0; m_leds = '0; m_err = 1'b0;
      m_rc = '0; m_wc = '0;
    end else begin
      m_v = (c == C_RD);
      if (c == C_RD) begin
        m_rc = m_rc + 16'd1;
        if (a < 9'h100)        m_rd = m_ram[a[7:0]];
        else if (a == 9'h140)  m_rd = {8'h00, sw};
        else begin m_rd = '0;  m_err = 1'b1; end
      end else if (c == C_WR) begin
        m_wc = m_wc + 16'd1;
        if (a < 9'h100)        m_ram[a[7:0]] = d;
        else if (a == 9'h100)  m_leds = d[7:0];
        else                   m_err = 1'b1;
      end else if (c == C_BAD) begin
        m_err = 1'b1;
      end
    end
    chk("read_valid", {31'd0, read_valid}, {31'd0, m_v});
    chk("read_data", {16'd0, read_data}, {16'd0, m_rd});
    chk("leds", {24'd0, leds}, {24'd0, m_leds});
    chk("bus_err", {31'd0, bus_err}, {31'd0, m_err});
`ifdef MEM_BUS_PERF_CNT_EN
    chk("rd_count", {16'd0, rd_count}, {16'd0, m_rc});
    chk("wr_count", {16'd0, wr_count}, {16'd0, m_wc});
`endif
  endtask

  function automatic logic [8:0] pick_addr();
    int k;
    k = int'($urandom_range(0, 9));
    if (k < 7)       return {1'b0, 8'($urandom)};
    else if (k == 7) return 9'h100;
    else if (k == 8) return 9'h140;
    else             return 9'($urandom);
  endfunction

  initial begin
    reset = 1'b1; mem_cmd = C_NONE; mem_addr = '0;
    write_data = '0; switches = '0;

    for (int i = 0; i < 3; i++) step(1, C_WR, 9'h100, 16'h00FF, 8'h00);

    for (int i = 0; i < 256; i++)
      step(0, C_WR, 9'(i), 16'($urandom), 8'h00);

    step(0, C_WR, 9'h005, 16'hA5A5, 8'h00);
    step(0, C_RD, 9'h005, 16'h0000, 8'h00);
    chk("raw_a5a5", {16'd0, read_data}, 32'h0000A5A5);
    step(0, C_NONE, 9'h000, 16'h0000, 8'h00);

    step(0, C_WR, 9'h001, 16'h0007, 8'h00);
    step(0, C_WR, 9'h002, 16'h0002, 8'h00);
    step(0, C_RD, 9'h001, 16'h0000, 8'h00);
    chk("b2b_first", {16'd0, read_data}, 32'h00000007);
    step(0, C_RD, 9'h002, 16'h0000, 8'h00);
    chk("b2b_second", {16'd0, read_data}, 32'h00000002);
    step(0, C_NONE, 9'h000, 16'h0000, 8'h00);

    step(0, C_RD, 9'h140, 16'h0000, 8'h3C);
    chk("switch_rd", {16'd0, read_data}, 32'h0000003C);
    step(0, C_WR, 9'h100, 16'h1281, 8'h00);
    chk("led_wr", {24'd0, leds}, 32'h00000081);

    step(0, C_RD, 9'h005, 16'h0000, 8'h00);
    step(1, C_NONE, 9'h000, 16'h0000, 8'h00);
    chk("rst_mid_data", {16'd0, read_data}, 32'h0);
    step(0, C_RD, 9'h005, 16'h0000, 8'h00);
    chk("ram_kept", {16'd0, read_data}, 32'h0000A5A5);

    step(0, C_RD, 9'h1F0, 16'h0000, 8'h00);
    chk("err_rd_set", {31'd0, bus_err}, 32'd1);
    step(0, C_BAD, 9'h005, 16'hFFFF, 8'h00);
    step(0, C_RD, 9'h005, 16'h0000, 8'h00);
    chk("illegal_noop", {16'd0, read_data}, 32'h0000A5A5);
    for (int i = 0; i < 3; i++) step(0, C_NONE, 9'h000, 16'h0, 8'h00);
    chk("err_sticky", {31'd0, bus_err}, 32'd1);

    for (int i = 0; i < 400; i++) begin
      int r;
      logic [1:0] c;
      r = int'($urandom_range(0, 99));
      c = (r < 40) ? C_RD : (r < 75) ? C_WR : (r < 97) ? C_NONE : C_BAD;
      step(0, c, pick_addr(), 16'($urandom), 8'($urandom));
    end

    step(1, C_WR, 9'h100, 16'h00AA, 8'h00);
    chk("err_cleared", {31'd0, bus_err}, 32'd0);

    step(0, C_RD, 9'h001, 16'h0, 8'h00);
    step(0, C_RD, 9'h140, 16'h0, 8'h11);
    step(0, C_RD, 9'h002, 16'h0, 8'h00);
    step(0, C_WR, 9'h003, 16'h1234, 8'h00);
    step(0, C_WR, 9'h100, 16'h0042, 8'h00);
`ifdef MEM_BUS_PERF_CNT_EN
    chk("rd_count_3", {16'd0, rd_count}, 32'd3);
    chk("wr_count_2", {16'd0, wr_count}, 32'd2);
`endif
    step(0, C_RD, 9'h003, 16'h0, 8'h00);
    chk("raw_final", {16'd0, read_data}, 32'h00001234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
